// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, debug-port and memory-side signals around the data memory arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) ();
  logic          cpu_rd;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          cpu_stall;
  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_lock;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_rdata;
  logic          proto_err;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    output dbg_rdata, dbg_ack,
    output mem_addr, mem_wdata, mem_rd, mem_wr, proto_err
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    input  dbg_rdata, dbg_ack,
    input  mem_addr, mem_wdata, mem_rd, mem_wr, proto_err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Serializes CPU and debug/loader accesses onto a single-port sync-read data memory.
module dmem_arbiter #(
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned FIXED  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);
  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          owner_cpu, owner_cpu_nxt;
  logic          last_cpu, last_cpu_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [DW-1:0] mem_wdata_nxt;
  logic          mem_rd_nxt, mem_wr_nxt;
  logic          cpu_ack_nxt, dbg_ack_nxt;
  logic [DW-1:0] cpu_rdata_nxt, dbg_rdata_nxt;
  logic          proto_err_nxt;
  logic          cpu_req, any_req, grant_cpu, grant_we;

  // Lock only masks new CPU grants; an in-flight CPU access always finishes.
  assign cpu_req   = (bus.cpu_rd | bus.cpu_wr) & ~bus.dbg_lock;
  assign any_req   = cpu_req | bus.dbg_req;
  assign grant_cpu = cpu_req & (~bus.dbg_req | (FIXED != 0) | ~last_cpu);
  assign grant_we  = grant_cpu ? bus.cpu_wr : bus.dbg_we;

  assign bus.cpu_stall = (bus.cpu_rd | bus.cpu_wr) & ~bus.cpu_ack;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = bus.mem_wr ? DONE : WAIT;
      WAIT:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for every registered output; strobes and acks are one-cycle pulses.
  always_comb begin
    cnt_nxt       = cnt;
    owner_cpu_nxt = owner_cpu;
    last_cpu_nxt  = last_cpu;
    mem_addr_nxt  = bus.mem_addr;
    mem_wdata_nxt = bus.mem_wdata;
    mem_rd_nxt    = 1'b0;
    mem_wr_nxt    = 1'b0;
    cpu_ack_nxt   = 1'b0;
    dbg_ack_nxt   = 1'b0;
    cpu_rdata_nxt = bus.cpu_rdata;
    dbg_rdata_nxt = bus.dbg_rdata;
    proto_err_nxt = bus.proto_err | (bus.cpu_rd & bus.cpu_wr);
    case (state)
      IDLE: begin
        if (any_req) begin
          owner_cpu_nxt = grant_cpu;
          last_cpu_nxt  = grant_cpu;
          mem_addr_nxt  = grant_cpu ? bus.cpu_addr  : bus.dbg_addr;
          mem_wdata_nxt = grant_cpu ? bus.cpu_wdata : bus.dbg_wdata;
          mem_wr_nxt    = grant_we;
          mem_rd_nxt    = ~grant_we;
        end
      end
      ISSUE: begin
        cnt_nxt = CW'(RD_LAT - 1);
        if (bus.mem_wr) begin
          cpu_ack_nxt = owner_cpu;
          dbg_ack_nxt = ~owner_cpu;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          cpu_ack_nxt = owner_cpu;
          dbg_ack_nxt = ~owner_cpu;
          if (owner_cpu) cpu_rdata_nxt = bus.mem_rdata;
          else           dbg_rdata_nxt = bus.mem_rdata;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt           <= '0;
      owner_cpu     <= 1'b0;
      last_cpu      <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_rd    <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.cpu_ack   <= 1'b0;
      bus.dbg_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.dbg_rdata <= '0;
      bus.proto_err <= 1'b0;
    end else begin
      cnt           <= cnt_nxt;
      owner_cpu     <= owner_cpu_nxt;
      last_cpu      <= last_cpu_nxt;
      bus.mem_addr  <= mem_addr_nxt;
      bus.mem_wdata <= mem_wdata_nxt;
      bus.mem_rd    <= mem_rd_nxt;
      bus.mem_wr    <= mem_wr_nxt;
      bus.cpu_ack   <= cpu_ack_nxt;
      bus.dbg_ack   <= dbg_ack_nxt;
      bus.cpu_rdata <= cpu_rdata_nxt;
      bus.dbg_rdata <= dbg_rdata_nxt;
      bus.proto_err <= proto_err_nxt;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: memory model, transaction scoreboard and read-data model.
module tb_dmem_arbiter;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(8), .DW(8)) b0 ();
  dmem_arbiter_if #(.AW(8), .DW(8)) b1 ();

  dmem_arbiter #(.AW(8), .DW(8), .RD_LAT(3), .FIXED(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  dmem_arbiter #(.AW(8), .DW(8), .RD_LAT(1), .FIXED(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  typedef struct packed {
    logic       cpu;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory for DUT0: read data appears RD_LAT=3 cycles after the mem_rd cycle.
  logic [7:0] mem [256];
  bit         wrote [256];
  logic [2:0] pv = '0;
  logic [7:0] pa0, pa1, pa2;

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return (a == 8'h40) ? 8'h3C : 8'h00;
  endfunction

  always @(posedge clk) begin
    pv  <= {pv[1:0], b0.mem_rd};
    pa0 <= b0.mem_addr;
    pa1 <= pa0;
    pa2 <= pa1;
    if (b0.mem_wr) begin
      mem[b0.mem_addr]   <= b0.mem_wdata;
      wrote[b0.mem_addr] <= 1'b1;
    end
  end

  assign b0.mem_rdata = pv[2] ? (wrote[pa2] ? mem[pa2] : init_val(pa2)) : 8'hEE;
  assign b1.mem_rdata = 8'h00;

  // Monitor for DUT0: strobes and acks against the scoreboard, rdata regs against a model.
  logic       mon_rst;
  logic       prev_strobe;
  logic [7:0] m_cpu, m_dbg;
  exp_t       e;
  initial forever begin
    @(posedge clk);
    mon_rst = rst_n;
    #2;
    if (!mon_rst) begin
      exp_q.delete();
      m_cpu       = 8'h00;
      m_dbg       = 8'h00;
      prev_strobe = 1'b0;
    end else begin
      if (b0.mem_rd || b0.mem_wr) begin
        check("strobe_excl", 32'(b0.mem_rd & b0.mem_wr), 0);
        check("strobe_1cyc", 32'(prev_strobe), 0);
        check("strobe_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          check("mem_we", 32'(b0.mem_wr), 32'(e.we));
          check("mem_addr", 32'(b0.mem_addr), 32'(e.addr));
          if (e.we) check("mem_wdata", 32'(b0.mem_wdata), 32'(e.wdata));
        end
      end
      prev_strobe = b0.mem_rd | b0.mem_wr;
      if (b0.cpu_ack || b0.dbg_ack) begin
        check("ack_excl", 32'(b0.cpu_ack & b0.dbg_ack), 0);
        check("ack_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("ack_port", 32'(b0.cpu_ack), 32'(e.cpu));
          if (!e.we) begin
            if (e.cpu) m_cpu = e.rdata;
            else       m_dbg = e.rdata;
          end
        end
      end
    end
    check("cpu_rdata", 32'(b0.cpu_rdata), 32'(m_cpu));
    check("dbg_rdata", 32'(b0.dbg_rdata), 32'(m_dbg));
  end

  task automatic wait_ack(input bit is_cpu, input int budget, output int n);
    bit got = 1'b0;
    n = -1;
    for (int i = 1; i <= budget && !got; i++) begin
      @(negedge clk);
      if (is_cpu ? b0.cpu_ack : b0.dbg_ack) begin
        got = 1'b1;
        n   = i;
      end
    end
  endtask

  task automatic cpu_txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [7:0] rdata, input int lat, input string tag);
    int n;
    exp_q.push_back('{cpu: 1'b1, we: we, addr: addr, wdata: wdata, rdata: rdata});
    b0.cpu_rd    = ~we;
    b0.cpu_wr    = we;
    b0.cpu_addr  = addr;
    b0.cpu_wdata = wdata;
    wait_ack(1'b1, 30, n);
    check(tag, n, lat);
    b0.cpu_rd = 1'b0;
    b0.cpu_wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic dbg_txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [7:0] rdata, input int lat, input string tag);
    int n;
    exp_q.push_back('{cpu: 1'b0, we: we, addr: addr, wdata: wdata, rdata: rdata});
    b0.dbg_req   = 1'b1;
    b0.dbg_we    = we;
    b0.dbg_addr  = addr;
    b0.dbg_wdata = wdata;
    wait_ack(1'b0, 30, n);
    check(tag, n, lat);
    b0.dbg_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n, acks, ca, da;
    bit got;
    {b0.cpu_rd, b0.cpu_wr, b0.dbg_req, b0.dbg_we, b0.dbg_lock} = '0;
    {b0.cpu_addr, b0.cpu_wdata, b0.dbg_addr, b0.dbg_wdata} = '0;
    {b1.cpu_rd, b1.cpu_wr, b1.dbg_req, b1.dbg_we, b1.dbg_lock} = '0;
    {b1.cpu_addr, b1.cpu_wdata, b1.dbg_addr, b1.dbg_wdata} = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: every output stays zero.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_data", {b0.cpu_rdata, b0.dbg_rdata, b0.mem_addr, b0.mem_wdata}, 0);
      check("idle_ctl", 32'({b0.cpu_ack, b0.cpu_stall, b0.dbg_ack, b0.mem_rd, b0.mem_wr, b0.proto_err}), 0);
    end

    cpu_txn(1'b1, 8'h12, 8'hA5, 8'h00, 2, "cpu_wr_lat");
    cpu_txn(1'b0, 8'h12, 8'h00, 8'hA5, 5, "cpu_rd_lat");
    dbg_txn(1'b0, 8'h40, 8'h00, 8'h3C, 5, "dbg_rd_lat");
    check("dbg_rd_val", 32'(b0.dbg_rdata), 32'h3C);
    check("cpu_rd_kept", 32'(b0.cpu_rdata), 32'hA5);

    // Both ports held: last grant was DBG, so CPU,DBG,CPU,DBG.
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back('{cpu: 1'b1, we: 1'b1, addr: 8'h20, wdata: 8'h11, rdata: 8'h00});
      exp_q.push_back('{cpu: 1'b0, we: 1'b1, addr: 8'h30, wdata: 8'h22, rdata: 8'h00});
    end
    b0.cpu_wr = 1'b1; b0.cpu_addr = 8'h20; b0.cpu_wdata = 8'h11;
    b0.dbg_req = 1'b1; b0.dbg_we = 1'b1; b0.dbg_addr = 8'h30; b0.dbg_wdata = 8'h22;
    acks = 0;
    for (int i = 0; i < 40 && acks < 4; i++) begin
      @(negedge clk);
      if (b0.cpu_ack || b0.dbg_ack) acks++;
    end
    b0.cpu_wr = 1'b0; b0.dbg_req = 1'b0;
    check("rr_acks", acks, 4);
    @(negedge clk);
    check("rr_sb_drained", exp_q.size(), 0);

    // Lock holds off a pending CPU read until it drops.
    b0.dbg_lock = 1'b1;
    exp_q.push_back('{cpu: 1'b1, we: 1'b0, addr: 8'h20, wdata: 8'h00, rdata: 8'h11});
    b0.cpu_rd = 1'b1; b0.cpu_addr = 8'h20;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("lock_hold", 32'({b0.cpu_stall, b0.cpu_ack, b0.mem_rd}), 32'b100);
    end
    b0.dbg_lock = 1'b0;
    wait_ack(1'b1, 30, n);
    check("lock_release_lat", n, 5);
    b0.cpu_rd = 1'b0;
    @(negedge clk);

    // Reset in the middle of a read wait: the read never acks.
    exp_q.push_back('{cpu: 1'b1, we: 1'b0, addr: 8'h30, wdata: 8'h00, rdata: 8'h22});
    b0.cpu_rd = 1'b1; b0.cpu_addr = 8'h30;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    b0.cpu_rd = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (b0.cpu_ack || b0.dbg_ack || b0.mem_rd || b0.mem_wr) acks++;
    end
    check("abort_no_ack", acks, 0);
    check("abort_rdata_cleared", 32'(b0.cpu_rdata), 0);
    cpu_txn(1'b0, 8'h12, 8'h00, 8'hA5, 5, "post_rst_rd_lat");

    // cpu_rd and cpu_wr together: handled as a write, error flag sticks.
    check("proto_clear", 32'(b0.proto_err), 0);
    exp_q.push_back('{cpu: 1'b1, we: 1'b1, addr: 8'h50, wdata: 8'h77, rdata: 8'h00});
    b0.cpu_rd = 1'b1; b0.cpu_wr = 1'b1; b0.cpu_addr = 8'h50; b0.cpu_wdata = 8'h77;
    wait_ack(1'b1, 30, n);
    check("proto_wr_lat", n, 2);
    check("proto_set", 32'(b0.proto_err), 1);
    b0.cpu_rd = 1'b0; b0.cpu_wr = 1'b0;
    repeat (4) @(negedge clk);
    check("proto_sticky", 32'(b0.proto_err), 1);

    // Fixed priority instance: CPU always wins while both are held.
    b1.cpu_wr = 1'b1; b1.cpu_addr = 8'h01; b1.cpu_wdata = 8'h5A;
    b1.dbg_req = 1'b1; b1.dbg_we = 1'b1; b1.dbg_addr = 8'h02; b1.dbg_wdata = 8'h6B;
    ca = 0; da = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (b1.cpu_ack) ca++;
      if (b1.dbg_ack) da++;
    end
    check("fixed_dbg_acks", da, 0);
    check("fixed_cpu_acks", 32'(ca >= 9), 1);
    b1.cpu_wr = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (b1.dbg_ack) got = 1'b1;
    end
    check("fixed_dbg_served", 32'(got), 1);
    b1.dbg_req = 1'b0;
    repeat (3) @(negedge clk);

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
